sys_os_array: RTL

- Parametrised output-stationary systolic MAC array. Each PE(r,c) accumulates the dot product of row stream a[r] and column stream w[c] over k_len vectors.
- Adds what the first-generation PE array lacks:
  - internal input skewing
  - valid-tagged bubbles
  - signed/unsigned mode
  - start/busy/done job sequencing
  - row-by-row result drain with valid/ready backpressure
- Sits between the operand feeders and the result writeback path of the accelerator datapath.

---
 rtl/sys_arr_pkg.sv | 30 +++
 rtl/sys_os_pe.sv | 55 +++++
 rtl/sys_os_array.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sys_arr_pkg.sv
// Shared definitions for the output-stationary systolic MAC array.
//   state_t   : job sequencer states.
//   flush_len : cycles needed after the last transfer for the far corner PE
//               to consume the final operand pair.
//   ext       : sign/zero extension of a dw-bit operand to EXT_W bits.
package sys_arr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Widest intermediate used for extension; callers truncate to AW (<= 64).
  localparam int EXT_W = 64;

  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] v,
                                           input int dw, input logic sgn);
    logic [EXT_W-1:0] mask;
    mask = {EXT_W{1'b1}} << dw;
    if (sgn && v[dw-1]) return v | mask;
    else                return v & ~mask;
  endfunction

endpackage

// File: rtl/sys_os_pe.sv
// One tagged MAC cell of the output-stationary array.
//   a_in/a_vin  : row operand and tag from the left; forwarded right via a_out/a_vout.
//   w_in/w_vin  : column operand and tag from above; forwarded down via w_out/w_vout.
//   clear       : zeroes the accumulator at job start.
//   signed_mode : selects sign or zero extension of both operands.
//   acc         : running sum, wraps modulo 2^AW.
module sys_os_pe
  import sys_arr_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          signed_mode,
  input  logic [DW-1:0] a_in,
  input  logic          a_vin,
  input  logic [DW-1:0] w_in,
  input  logic          w_vin,
  output logic [DW-1:0] a_out,
  output logic          a_vout,
  output logic [DW-1:0] w_out,
  output logic          w_vout,
  output logic [AW-1:0] acc
);

  logic [AW-1:0] ea, ew, prod;

  // Product taken at AW bits: the low AW bits of the full product are all
  // that survive the modulo-2^AW accumulation.
  always_comb begin
    ea   = AW'(ext(EXT_W'(a_in), DW, signed_mode));
    ew   = AW'(ext(EXT_W'(w_in), DW, signed_mode));
    prod = ea * ew;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_out  <= '0;
      a_vout <= 1'b0;
      w_out  <= '0;
      w_vout <= 1'b0;
      acc    <= '0;
    end else begin
      a_out  <= a_in;
      a_vout <= a_vin;
      w_out  <= w_in;
      w_vout <= w_vin;
      if (clear)              acc <= '0;
      else if (a_vin && w_vin) acc <= acc + prod;
    end
  end

endmodule

// File: rtl/sys_os_array.sv
// Output-stationary ROWS x COLS systolic MAC array with input skewing,
// valid-tagged bubbles, signed/unsigned operands, job sequencing and a
// row-by-row result drain.
//   start/k_len/signed_mode : job request, honoured in IDLE only.
//   in_valid/in_ready/in_a/in_w : operand stream. Handshake: a vector pair
//       transfers on a cycle where in_valid && in_ready; in_ready is high
//       only in LOAD. out_valid/out_ready follow the same rule; out_row and
//       out_row_idx hold steady while out_valid && !out_ready.
//   busy/done : busy while not IDLE; done pulses on DRAIN->IDLE.
//   out_row/out_row_idx : accumulators of one PE row and its index.
//   state_dbg : current sequencer state for observation.
module sys_os_array
  import sys_arr_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  parameter int KW   = 16,
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 signed_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   in_a,
  input  logic [COLS*DW-1:0]   in_w,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*AW-1:0]   out_row,
  output logic [RIW-1:0]       out_row_idx,
  output logic [1:0]           state_dbg
);

  localparam int FL = flush_len(ROWS, COLS);
  localparam int FW = $clog2(FL + 1);

  state_t        state;
  logic [KW-1:0] rem;
  logic [FW-1:0] fcnt;
  logic          sgn;
  logic          xfer, clear;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign state_dbg = state;
  assign xfer      = in_valid && in_ready;
  assign clear     = start && (state == IDLE);

  // Grid wiring: a_h[r][c] enters PE(r,c) from the left, w_v[r][c] from above.
  logic [DW-1:0] a_h  [ROWS][COLS+1];
  logic          av_h [ROWS][COLS+1];
  logic [DW-1:0] w_v  [ROWS+1][COLS];
  logic          wv_v [ROWS+1][COLS];
  logic [AW-1:0] acc  [ROWS][COLS];

  // Row r is delayed r cycles so its data meets column data on the diagonal.
  // The tag is the transfer itself, so idle cycles become bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    if (r == 0) begin : g_direct
      assign a_h[0][0]  = in_a[DW-1:0];
      assign av_h[0][0] = xfer;
    end else begin : g_chain
      logic [DW-1:0] d [1:r];
      logic          v [1:r];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int s = 1; s <= r; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[1] <= in_a[r*DW +: DW];
          v[1] <= xfer;
          for (int s = 2; s <= r; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign a_h[r][0]  = d[r];
      assign av_h[r][0] = v[r];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    if (c == 0) begin : g_direct
      assign w_v[0][0]  = in_w[DW-1:0];
      assign wv_v[0][0] = xfer;
    end else begin : g_chain
      logic [DW-1:0] d [1:c];
      logic          v [1:c];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int s = 1; s <= c; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[1] <= in_w[c*DW +: DW];
          v[1] <= xfer;
          for (int s = 2; s <= c; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign w_v[0][c]  = d[c];
      assign wv_v[0][c] = v[c];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      sys_os_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (clear),
        .signed_mode (sgn),
        .a_in        (a_h[r][c]),
        .a_vin       (av_h[r][c]),
        .w_in        (w_v[r][c]),
        .w_vin       (wv_v[r][c]),
        .a_out       (a_h[r][c+1]),
        .a_vout      (av_h[r][c+1]),
        .w_out       (w_v[r+1][c]),
        .w_vout      (wv_v[r+1][c]),
        .acc         (acc[r][c])
      );
    end
  end

  // Outputs leaving the right and bottom edges have no consumer.
  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int r = 0; r < ROWS; r++) unused_edge ^= ^{a_h[r][COLS], av_h[r][COLS]};
    for (int c = 0; c < COLS; c++) unused_edge ^= ^{w_v[ROWS][c], wv_v[ROWS][c]};
  end

  // Accumulators are frozen in DRAIN (no tags in flight), so the mux output
  // is stable whenever out_row_idx is held.
  always_comb begin
    out_row = '0;
    for (int c = 0; c < COLS; c++) out_row[c*AW +: AW] = acc[out_row_idx][c];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rem         <= '0;
      fcnt        <= '0;
      sgn         <= 1'b0;
      done        <= 1'b0;
      out_row_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rem   <= k_len;
          sgn   <= signed_mode;
          state <= (k_len == '0) ? DRAIN : LOAD;
        end
        LOAD: if (xfer) begin
          rem <= rem - KW'(1);
          if (rem == KW'(1)) begin
            state <= FLUSH;
            fcnt  <= FW'(FL - 1);
          end
        end
        FLUSH: begin
          if (fcnt == '0) state <= DRAIN;
          else            fcnt  <= fcnt - FW'(1);
        end
        DRAIN: if (out_ready) begin
          if (out_row_idx == RIW'(ROWS - 1)) begin
            out_row_idx <= '0;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            out_row_idx <= out_row_idx + RIW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
